// File: rtl/reverse_100bit_deser.sv
// Bit-serial receiver. Collects WIDTH accepted bits into an assembly register,
// optionally bit-reversed, and hands each completed word to a one-word
// valid/ready holding register. Overflow and frame errors are sticky.
module reverse_100bit_deser #(
    parameter  int WIDTH   = 100,
    parameter  int REVERSE = 1,
    localparam int CW      = $clog2(WIDTH + 1),
    localparam int IW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] word_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    bit_count,
    output logic             overflow,
    output logic             frame_err
);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t             state, nxt_state;
    logic [WIDTH-1:0]   sreg, nxt_sreg;
    logic [WIDTH-1:0]   nxt_word;
    logic               nxt_out_valid;
    logic [CW-1:0]      nxt_count;
    logic               nxt_overflow, nxt_frame_err;

    logic [CW-1:0]      k;
    logic [IW-1:0]      pos;
    logic [WIDTH-1:0]   asm_word;
    logic               last_bit;

    // Register all state; everything visible at the ports comes from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            word_out  <= '0;
            out_valid <= 1'b0;
            bit_count <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= nxt_state;
            sreg      <= nxt_sreg;
            word_out  <= nxt_word;
            out_valid <= nxt_out_valid;
            bit_count <= nxt_count;
            overflow  <= nxt_overflow;
            frame_err <= nxt_frame_err;
        end
    end

    // Next-state: bit placement, completion handoff, frame restart and flags.
    always_comb begin
        nxt_state     = state;
        nxt_sreg      = sreg;
        nxt_word      = word_out;
        nxt_out_valid = out_valid;
        nxt_count     = bit_count;
        nxt_overflow  = overflow;
        nxt_frame_err = frame_err;

        // A restart makes the bit sampled this cycle the first of the new frame,
        // placed into a cleared register so stale partial bits never leak.
        k        = frame_start ? '0 : bit_count;
        pos      = (REVERSE != 0) ? (IW'(WIDTH - 1) - k[IW-1:0]) : k[IW-1:0];
        asm_word = frame_start ? '0 : sreg;
        asm_word[pos] = bit_in;
        last_bit = (bit_count == CW'(WIDTH - 1));

        if (out_valid && out_ready)
            nxt_out_valid = 1'b0;

        // Clear first so a same-cycle set below wins.
        if (clr_flags) begin
            nxt_overflow  = 1'b0;
            nxt_frame_err = 1'b0;
        end

        if (frame_start) begin
            nxt_sreg  = '0;
            nxt_count = '0;
            nxt_state = IDLE;
            if (bit_count != '0)
                nxt_frame_err = 1'b1;
            // WIDTH >= 2, so the restart bit can never complete a word.
            if (bit_valid) begin
                nxt_sreg  = asm_word;
                nxt_count = CW'(1);
                nxt_state = COLLECT;
            end
        end else if (bit_valid) begin
            if (last_bit) begin
                nxt_sreg  = '0;
                nxt_count = '0;
                nxt_state = IDLE;
                // Holding register is free, or being emptied on this same edge.
                if (!out_valid || out_ready) begin
                    nxt_word      = asm_word;
                    nxt_out_valid = 1'b1;
                end else begin
                    nxt_overflow  = 1'b1;
                end
            end else begin
                nxt_sreg  = asm_word;
                nxt_count = bit_count + CW'(1);
                nxt_state = COLLECT;
            end
        end
    end

endmodule
